udma_spim_mch_reg_if: RTL and testbench
=======================================

Name: udma_spim_mch_reg_if

Overview:
Parametrised successor of the SPIM uDMA register interface. It generalises the fixed CMD/RX/TX channel set to N_CH identical uDMA channels, each with a start address, size, config and status register. It decodes SETUP_UCA/SETUP_UCS commands from the command stream, now addressed by channel index. It adds per-channel sticky done/overflow status, a masked interrupt, and a stall handshake, so a config write that collides with a command is delayed rather than dropped.

Parameters:
N_CH, 3, number of channels; legal range 1..7.
L2_AWIDTH_NOAL, 12, L2 address width.
TRANS_SIZE, 16, transfer size width.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_data_i  in  32  APB-side write data
cfg_addr_i  in  5  register word address
cfg_valid_i  in  1  access request
cfg_rwn_i  in  1  1=read, 0=write
cfg_data_o  out  32  read data, combinational
cfg_ready_o  out  1  access accepted this cycle
cfg_startaddr_o  out  N_CH*L2_AWIDTH_NOAL  per-channel start address
cfg_size_o  out  N_CH*TRANS_SIZE  per-channel size
cfg_datasize_o  out  N_CH*2  per-channel datasize
cfg_continuous_o  out  N_CH  per-channel continuous mode
cfg_en_o  out  N_CH  one-cycle enable pulse
cfg_clr_o  out  N_CH  one-cycle clear pulse
cfg_en_i  in  N_CH  channel enabled (from uDMA core)
cfg_pending_i  in  N_CH  channel has a queued transfer
cfg_curr_addr_i  in  N_CH*L2_AWIDTH_NOAL  current address
cfg_bytes_left_i  in  N_CH*TRANS_SIZE  bytes remaining
udma_cmd_i  in  32  command word
udma_cmd_valid_i  in  1  command valid
udma_cmd_ready_i  in  1  command consumed
irq_o  out  1  registered masked interrupt

Behaviour:
- Register map: channel c occupies 4c+0 SADDR, 4c+1 SIZE, 4c+2 CFG, 4c+3 STATUS. 0x1C is IRQ_EN (bits N_CH-1:0). 0x1D is IRQ_STATUS (read-only, bit c = OR of the channel's sticky bits).
- Unmapped addresses: writes are ignored; reads return 0.
- SADDR and SIZE: writes load the register. Reads return curr_addr and bytes_left, zero-extended.
- CFG write:
  - bit0 -> continuous.
  - bits2:1 -> datasize.
  - bit4 -> en request.
  - bit5 -> clr request.
- CFG read: {26'h0, pending_i, en_i, 1'b0, datasize, continuous}.
- STATUS: bit0 = done (sticky), bit1 = overflow (sticky). Write-1-to-clear.
- Command decode fires when udma_cmd_valid_i & udma_cmd_ready_i & cmd[31:28] is `SPI_CMD_SETUP_UCA or `SPI_CMD_SETUP_UCS.
  - Channel index = cmd[27:25]; datasize = cmd[24:23].
  - UCA: startaddr[ch] <= cmd[L2_AWIDTH_NOAL-1:0].
  - UCS: size[ch] <= cmd[TRANS_SIZE-1:0]; datasize[ch] <= cmd[24:23]; en request for ch.
  - Channel index >= N_CH: the command is ignored with no side effects.
- Stall handshake:
  - cfg_ready_o = ~(cmd_fire & cfg_valid_i & ~cfg_rwn_i). Reads are always ready.
  - On a stall the write is not applied; the master holds it, and it is applied in the first cycle without a command fire.
- En/clr pulses:
  - cfg_en_o[c] and cfg_clr_o[c] are registered. They assert for exactly one cycle, on the cycle after the accepted write or command fire.
  - clr and en in the same write: both pulse.
- Overflow rule:
  - An en request while pending_i[c]=1 produces no en pulse and sets overflow[c].
  - The pending_i check is sampled in the same cycle as the request.
- Done detection:
  - en_d[c] is a registered copy of en_i[c].
  - done[c] is set when en_d[c] & ~en_i[c] & ~pending_i[c].
- Set/clear priority: if a status set event and a W1C of the same bit coincide, set wins.
- clr pulse clears both sticky bits of that channel, one cycle after the write.
- irq_o is registered: irq_o <= |(IRQ_EN & IRQ_STATUS). Latency is one cycle after a sticky bit sets.
- Reset values:
  - All startaddr, size, continuous, en, clr, status, IRQ_EN and irq_o are 0.
  - datasize = 2'b10.
  - en_d = 0.
  - Reset mid-operation aborts pending pulses; no spurious pulse follows reset release.

Test Plan:
- Reset, then read every mapped address -> CFG reads datasize=2, all other fields and irq_o are 0, cfg_ready_o=1.
- Write 0x10 to addr 6 (ch1 CFG) -> cfg_en_o=3'b010 for exactly one cycle, on the next clock.
- UCS command on ch2 with size=0x40 and ds=1, while a write is issued to addr 0 in the same cycle:
  - cfg_ready_o=0 that cycle.
  - size[2]=0x40, datasize[2]=1, en pulse on ch2.
  - The write lands one cycle later.
- With pending_i[0]=1, write en to ch0 -> no en pulse; STATUS0 reads 0x2. W1C 0x2 -> reads 0.
- IRQ_EN=0x1; en_i[0] falls with pending_i[0]=0 -> STATUS0=0x1 and irq_o=1 one cycle later. W1C in the same cycle as a new done event -> bit stays 1.
- UCA command with channel index 7 (N_CH=3) -> no register changes.

Source files
------------

// File: rtl/udma_spim_mch_reg_if.sv
// SPIM uDMA register interface for N_CH identical channels: config registers, command-stream
// channel setup, sticky done/overflow status with masked interrupt, and write stall on collisions.
module udma_spim_mch_reg_if #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [31:0]                      cfg_data_i,
  input  logic [4:0]                       cfg_addr_i,
  input  logic                             cfg_valid_i,
  input  logic                             cfg_rwn_i,
  output logic [31:0]                      cfg_data_o,
  output logic                             cfg_ready_o,
  output logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]       cfg_size_o,
  output logic [N_CH*2-1:0]                cfg_datasize_o,
  output logic [N_CH-1:0]                  cfg_continuous_o,
  output logic [N_CH-1:0]                  cfg_en_o,
  output logic [N_CH-1:0]                  cfg_clr_o,
  input  logic [N_CH-1:0]                  cfg_en_i,
  input  logic [N_CH-1:0]                  cfg_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]       cfg_bytes_left_i,
  input  logic [31:0]                      udma_cmd_i,
  input  logic                             udma_cmd_valid_i,
  input  logic                             udma_cmd_ready_i,
  output logic                             irq_o
);

  // SPIM command opcodes for channel setup
  localparam logic [3:0] SpiCmdSetupUca = 4'hD;
  localparam logic [3:0] SpiCmdSetupUcs = 4'hE;
  localparam logic [4:0] AddrIrqEn      = 5'h1C;
  localparam logic [4:0] AddrIrqStatus  = 5'h1D;

  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0] startaddr_q, startaddr_d;
  logic [N_CH-1:0][TRANS_SIZE-1:0]     size_q, size_d;
  logic [N_CH-1:0][1:0]                datasize_q, datasize_d;
  logic [N_CH-1:0] continuous_q, continuous_d;
  logic [N_CH-1:0] en_q, en_d, clr_q, clr_d;
  logic [N_CH-1:0] done_q, done_d, ovf_q, ovf_d;
  logic [N_CH-1:0] en_prev_q, irq_en_q, irq_en_d;
  logic            irq_q, irq_d;

  logic [N_CH-1:0] en_req, w1c_done, w1c_ovf, irq_status;
  logic [3:0]      cmd_op;
  logic [2:0]      cmd_ch;
  logic            cmd_fire, cmd_is_ucs, wr_acc;
  logic            unused_bits;

  assign cmd_op     = udma_cmd_i[31:28];
  assign cmd_ch     = udma_cmd_i[27:25];
  assign cmd_is_ucs = (cmd_op == SpiCmdSetupUcs);
  // Commands addressing a nonexistent channel do not fire, so they never stall a write either.
  assign cmd_fire   = udma_cmd_valid_i & udma_cmd_ready_i &
                      ((cmd_op == SpiCmdSetupUca) | cmd_is_ucs) & ({29'd0, cmd_ch} < N_CH);
  assign cfg_ready_o = ~(cmd_fire & cfg_valid_i & ~cfg_rwn_i);
  assign wr_acc      = cfg_valid_i & ~cfg_rwn_i & ~cmd_fire;
  assign irq_status  = done_q | ovf_q;
  assign unused_bits = ^{cfg_data_i, udma_cmd_i};

  always_comb begin
    startaddr_d  = startaddr_q;
    size_d       = size_q;
    datasize_d   = datasize_q;
    continuous_d = continuous_q;
    irq_en_d     = irq_en_q;
    en_d         = '0;
    clr_d        = '0;
    done_d       = done_q;
    ovf_d        = ovf_q;
    en_req       = '0;
    w1c_done     = '0;
    w1c_ovf      = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (wr_acc) begin
        if (cfg_addr_i == 5'(c * 4)) startaddr_d[c] = cfg_data_i[L2_AWIDTH_NOAL-1:0];
        if (cfg_addr_i == 5'(c * 4 + 1)) size_d[c] = cfg_data_i[TRANS_SIZE-1:0];
        if (cfg_addr_i == 5'(c * 4 + 2)) begin
          continuous_d[c] = cfg_data_i[0];
          datasize_d[c]   = cfg_data_i[2:1];
          en_req[c]       = cfg_data_i[4];
          clr_d[c]        = cfg_data_i[5];
        end
        if (cfg_addr_i == 5'(c * 4 + 3)) begin
          w1c_done[c] = cfg_data_i[0];
          w1c_ovf[c]  = cfg_data_i[1];
        end
      end
      if (cmd_fire && (cmd_ch == 3'(c))) begin
        if (cmd_is_ucs) begin
          size_d[c]     = udma_cmd_i[TRANS_SIZE-1:0];
          datasize_d[c] = udma_cmd_i[24:23];
          en_req[c]     = 1'b1;
        end else begin
          startaddr_d[c] = udma_cmd_i[L2_AWIDTH_NOAL-1:0];
        end
      end
      // An enable request against a busy queue is refused and flagged as overflow.
      en_d[c]   = en_req[c] & ~cfg_pending_i[c];
      done_d[c] = (en_prev_q[c] & ~cfg_en_i[c] & ~cfg_pending_i[c]) |
                  (done_q[c] & ~w1c_done[c] & ~clr_q[c]);
      ovf_d[c]  = (en_req[c] & cfg_pending_i[c]) | (ovf_q[c] & ~w1c_ovf[c] & ~clr_q[c]);
    end
    if (wr_acc && (cfg_addr_i == AddrIrqEn)) irq_en_d = cfg_data_i[N_CH-1:0];
    irq_d = |(irq_en_q & irq_status);
  end

  always_comb begin
    cfg_data_o = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cfg_addr_i == 5'(c * 4)) begin
        cfg_data_o = 32'(cfg_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
      end
      if (cfg_addr_i == 5'(c * 4 + 1)) begin
        cfg_data_o = 32'(cfg_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]);
      end
      if (cfg_addr_i == 5'(c * 4 + 2)) begin
        cfg_data_o = {26'h0, cfg_pending_i[c], cfg_en_i[c], 1'b0, datasize_q[c], continuous_q[c]};
      end
      if (cfg_addr_i == 5'(c * 4 + 3)) cfg_data_o = {30'h0, ovf_q[c], done_q[c]};
    end
    if (cfg_addr_i == AddrIrqEn)     cfg_data_o = 32'(irq_en_q);
    if (cfg_addr_i == AddrIrqStatus) cfg_data_o = 32'(irq_status);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      startaddr_q  <= '0;
      size_q       <= '0;
      datasize_q   <= {N_CH{2'b10}};
      continuous_q <= '0;
      en_q         <= '0;
      clr_q        <= '0;
      done_q       <= '0;
      ovf_q        <= '0;
      en_prev_q    <= '0;
      irq_en_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      startaddr_q  <= startaddr_d;
      size_q       <= size_d;
      datasize_q   <= datasize_d;
      continuous_q <= continuous_d;
      en_q         <= en_d;
      clr_q        <= clr_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      en_prev_q    <= cfg_en_i;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

  assign cfg_startaddr_o  = startaddr_q;
  assign cfg_size_o       = size_q;
  assign cfg_datasize_o   = datasize_q;
  assign cfg_continuous_o = continuous_q;
  assign cfg_en_o         = en_q;
  assign cfg_clr_o        = clr_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_udma_spim_mch_reg_if.sv
// Self-checking bench for udma_spim_mch_reg_if: register read table plus command/stall/status
// sequences; read data is checked through a scoreboard queue.
module tb_udma_spim_mch_reg_if;

  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 12;
  localparam int unsigned TS  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [31:0]       cfg_data_i, cfg_data_o;
  logic [4:0]        cfg_addr_i;
  logic              cfg_valid_i, cfg_rwn_i, cfg_ready_o;
  logic [NCH*AW-1:0] cfg_startaddr_o, cfg_curr_addr_i;
  logic [NCH*TS-1:0] cfg_size_o, cfg_bytes_left_i;
  logic [NCH*2-1:0]  cfg_datasize_o;
  logic [NCH-1:0]    cfg_continuous_o, cfg_en_o, cfg_clr_o, cfg_en_i, cfg_pending_i;
  logic [31:0]       udma_cmd_i;
  logic              udma_cmd_valid_i, udma_cmd_ready_i, irq_o;

  udma_spim_mch_reg_if #(.N_CH(NCH), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .cfg_data_i       (cfg_data_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_rwn_i        (cfg_rwn_i),
    .cfg_data_o       (cfg_data_o),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_startaddr_o  (cfg_startaddr_o),
    .cfg_size_o       (cfg_size_o),
    .cfg_datasize_o   (cfg_datasize_o),
    .cfg_continuous_o (cfg_continuous_o),
    .cfg_en_o         (cfg_en_o),
    .cfg_clr_o        (cfg_clr_o),
    .cfg_en_i         (cfg_en_i),
    .cfg_pending_i    (cfg_pending_i),
    .cfg_curr_addr_i  (cfg_curr_addr_i),
    .cfg_bytes_left_i (cfg_bytes_left_i),
    .udma_cmd_i       (udma_cmd_i),
    .udma_cmd_valid_i (udma_cmd_valid_i),
    .udma_cmd_ready_i (udma_cmd_ready_i),
    .irq_o            (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[16];
  int   checks   = 0;
  int   failures = 0;

  // Expected register outputs, maintained alongside the stimulus.
  logic [NCH*AW-1:0] exp_sa;
  logic [NCH*TS-1:0] exp_sz;
  logic [NCH*2-1:0]  exp_ds;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read: push expectation, drive, pop and compare once the combinational data is settled.
  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string name);
    exp_t x;
    x.name = name;
    x.val  = e;
    sb_q.push_back(x);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b1;
    cfg_addr_i  = a;
    @(negedge clk);
    check({name, "_rdy"}, 64'(cfg_ready_o), 64'd1);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      x = sb_q.pop_front();
      check(x.name, 64'(cfg_data_o), 64'(x.val));
    end
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bit ok;
    ok          = 1'b0;
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b0;
    cfg_addr_i  = a;
    cfg_data_i  = d;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      ok = cfg_ready_o;
      if (!ok) @(posedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wr_timeout: addr 0x%0h never accepted", a);
    end
    tick();
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    rstn             = 1'b0;
    cfg_data_i       = '0;
    cfg_addr_i       = '0;
    cfg_valid_i      = 1'b0;
    cfg_rwn_i        = 1'b1;
    cfg_en_i         = '0;
    cfg_pending_i    = '0;
    cfg_curr_addr_i  = {12'h333, 12'h222, 12'h111};
    cfg_bytes_left_i = {16'h3000, 16'h2000, 16'h1000};
    udma_cmd_i       = '0;
    udma_cmd_valid_i = 1'b0;
    udma_cmd_ready_i = 1'b0;
    exp_sa           = '0;
    exp_sz           = '0;
    exp_ds           = 6'b101010;

    tbl = '{'{5'd0, 32'h111}, '{5'd1, 32'h1000}, '{5'd2, 32'h4}, '{5'd3, 32'h0},
            '{5'd4, 32'h222}, '{5'd5, 32'h2000}, '{5'd6, 32'h4}, '{5'd7, 32'h0},
            '{5'd8, 32'h333}, '{5'd9, 32'h3000}, '{5'd10, 32'h4}, '{5'd11, 32'h0},
            '{5'd28, 32'h0}, '{5'd29, 32'h0}, '{5'd12, 32'h0}, '{5'd31, 32'h0}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Reset state
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_sa", 64'(cfg_startaddr_o), 64'(exp_sa));
    check("rst_sz", 64'(cfg_size_o), 64'(exp_sz));
    check("rst_ds", 64'(cfg_datasize_o), 64'(exp_ds));
    check("rst_en_clr", 64'({cfg_continuous_o, cfg_en_o, cfg_clr_o}), 64'd0);
    for (int i = 0; i < 16; i++) rd(tbl[i].addr, tbl[i].exp, $sformatf("rd_a%0d", tbl[i].addr));

    // Channel 1 enable through CFG write
    wr(5'd6, 32'h10);
    exp_ds[3:2] = 2'b00;
    check("en_pulse_ch1", 64'(cfg_en_o), 64'b010);
    tick();
    check("en_pulse_ch1_end", 64'(cfg_en_o), 64'd0);

    // UCS on ch2 colliding with a write to ch0 SADDR
    udma_cmd_i       = {4'hE, 3'd2, 2'd1, 7'd0, 16'h0040};
    udma_cmd_valid_i = 1'b1;
    udma_cmd_ready_i = 1'b1;
    cfg_valid_i      = 1'b1;
    cfg_rwn_i        = 1'b0;
    cfg_addr_i       = 5'd0;
    cfg_data_i       = 32'hABC;
    @(negedge clk);
    check("stall_ready", 64'(cfg_ready_o), 64'd0);
    tick();
    udma_cmd_valid_i = 1'b0;
    udma_cmd_ready_i = 1'b0;
    exp_sz[47:32]    = 16'h40;
    exp_ds[5:4]      = 2'd1;
    @(negedge clk);
    check("stall_released", 64'(cfg_ready_o), 64'd1);
    check("ucs_en_ch2", 64'(cfg_en_o), 64'b100);
    check("ucs_size", 64'(cfg_size_o), 64'(exp_sz));
    check("ucs_ds", 64'(cfg_datasize_o), 64'(exp_ds));
    check("stalled_not_applied", 64'(cfg_startaddr_o), 64'(exp_sa));
    tick();
    cfg_valid_i  = 1'b0;
    exp_sa[11:0] = 12'hABC;
    check("stalled_applied", 64'(cfg_startaddr_o), 64'(exp_sa));
    check("ucs_en_end", 64'(cfg_en_o), 64'd0);

    // Read during a command fire is never stalled; UCS on ch0
    udma_cmd_i       = {4'hE, 3'd0, 2'd2, 7'd0, 16'h0008};
    udma_cmd_valid_i = 1'b1;
    udma_cmd_ready_i = 1'b1;
    rd(5'd1, 32'h1000, "rd_during_cmd");
    udma_cmd_valid_i = 1'b0;
    udma_cmd_ready_i = 1'b0;
    exp_sz[15:0]     = 16'h8;
    exp_ds[1:0]      = 2'd2;
    check("ucs_en_ch0", 64'(cfg_en_o), 64'b001);
    check("ucs_size_ch0", 64'(cfg_size_o), 64'(exp_sz));

    // Overflow: enable while pending
    cfg_pending_i[0] = 1'b1;
    wr(5'd2, 32'h10);
    exp_ds[1:0] = 2'b00;
    check("ovf_no_pulse", 64'(cfg_en_o), 64'd0);
    rd(5'd2, 32'h20, "cfg0_pending");
    rd(5'd3, 32'h2, "stat0_ovf");
    wr(5'd3, 32'h2);
    rd(5'd3, 32'h0, "stat0_ovf_w1c");

    // clr pulse wipes sticky bits one cycle later
    wr(5'd2, 32'h10);
    cfg_pending_i[0] = 1'b0;
    wr(5'd2, 32'h20);
    check("clr_pulse", 64'(cfg_clr_o), 64'b001);
    tick();
    check("clr_pulse_end", 64'(cfg_clr_o), 64'd0);
    rd(5'd3, 32'h0, "stat0_after_clr");

    // Done detection and interrupt
    wr(5'd28, 32'h1);
    cfg_en_i[0] = 1'b1;
    tick();
    cfg_en_i[0] = 1'b0;
    tick();
    check("irq_lag", 64'(irq_o), 64'd0);
    rd(5'd3, 32'h1, "stat0_done");
    check("irq_set", 64'(irq_o), 64'd1);
    rd(5'd29, 32'h1, "irq_status");
    cfg_en_i[0] = 1'b1;
    tick();
    cfg_en_i[0] = 1'b0;
    wr(5'd3, 32'h1);
    check("irq_hold", 64'(irq_o), 64'd1);
    rd(5'd3, 32'h1, "stat0_set_wins");
    wr(5'd3, 32'h1);
    rd(5'd3, 32'h0, "stat0_cleared");
    check("irq_clear", 64'(irq_o), 64'd0);

    // UCA on ch1, then UCA/UCS on ch7 ignored
    udma_cmd_i       = {4'hD, 3'd1, 13'd0, 12'h5A5};
    udma_cmd_valid_i = 1'b1;
    udma_cmd_ready_i = 1'b1;
    tick();
    exp_sa[23:12] = 12'h5A5;
    udma_cmd_i    = {4'hD, 3'd7, 13'd0, 12'hFFF};
    tick();
    udma_cmd_i    = {4'hE, 3'd7, 2'd3, 7'd0, 16'hFFFF};
    tick();
    check("ch7_no_en", 64'(cfg_en_o), 64'd0);
    udma_cmd_valid_i = 1'b0;
    udma_cmd_ready_i = 1'b0;
    tick();
    check("uca_ch1_sa", 64'(cfg_startaddr_o), 64'(exp_sa));
    check("ch7_sz", 64'(cfg_size_o), 64'(exp_sz));
    check("ch7_ds", 64'(cfg_datasize_o), 64'(exp_ds));

    // Reset while an enable write is in flight
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b0;
    cfg_addr_i  = 5'd2;
    cfg_data_i  = 32'h10;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    cfg_valid_i = 1'b0;
    check("rst_abort_en", 64'(cfg_en_o), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("rst_no_spurious", 64'(cfg_en_o), 64'd0);
    check("rst_ds_again", 64'(cfg_datasize_o), 64'b101010);
    check("rst_sa_again", 64'(cfg_startaddr_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
